weight_stream_gen: RTL and testbench

//  Generic weight/coefficient streamer for conv layers, successor to the per-layer fixed weight blocks.

---
 rtl/weight_stream_gen_if.sv | 31 +++
 rtl/weight_stream_gen.sv | 110 +++++++++++
 tb/tb_weight_stream_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_gen_if.sv
// ROM read port and output stream port of weight_stream_gen, bundled as one interface.
// The master side is the streamer; the slave side is the ROM plus the downstream FIFO.
interface weight_stream_gen_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] weight_V_address0;
  logic              weight_V_ce0;
  logic [DATA_W-1:0] weight_V_q0;
  logic [DATA_W-1:0] output_V_din;
  logic              output_V_full_n;
  logic              output_V_write;

  modport master (
    output weight_V_address0,
    output weight_V_ce0,
    input  weight_V_q0,
    output output_V_din,
    input  output_V_full_n,
    output output_V_write
  );

  modport slave (
    input  weight_V_address0,
    input  weight_V_ce0,
    output weight_V_q0,
    input  output_V_din,
    output output_V_full_n,
    input  output_V_write
  );
endinterface

// File: rtl/weight_stream_gen.sv
// Streams a kernel's coefficients from a 1-cycle-latency ROM into a FIFO port,
// replaying the kernel REPEAT times per start (or forever in CONTINUOUS mode).
module weight_stream_gen #(
  parameter int COEFF_WIDTH = 16,
  parameter int LANES       = 1,
  parameter int KERN_SIZE   = 288,
  parameter int REPEAT      = 1,
  parameter int CONTINUOUS  = 0,
  localparam int ADDR_W     = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1,
  localparam int DATA_W     = LANES * COEFF_WIDTH
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic [1:0]  state_dbg,
  weight_stream_gen_if.master bus
);

  localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KERN_SIZE - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPEAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [PASS_W-1:0] pass;
  logic [DATA_W-1:0] buf0, buf1;
  logic [1:0]        count;
  logic              inflight;
  logic              pop, push, issue, last_read;
  logic [2:0]        occ_after_pop;

  // Handshake: a word transfers on every cycle output_V_write is high; write is
  // only raised while full_n is high, and din (head entry) is stable otherwise.
  assign pop  = (count != 2'd0) && bus.output_V_full_n;
  assign push = inflight;

  // Buffered plus in-flight words after this cycle's pop must leave room for
  // one more read, so the 2-entry buffer can never overflow.
  assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = (state == S_RUN) && (occ_after_pop < 3'd2);
  assign last_read     = issue && (addr == LAST_ADDR) && (pass == LAST_PASS);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (ap_start) state_nxt = S_RUN;
      S_RUN:   if (last_read) state_nxt = S_DRAIN;
      S_DRAIN: if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop)))
                 state_nxt = S_DONE;
      S_DONE:  state_nxt = (CONTINUOUS != 0) ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      pass     <= '0;
      buf0     <= '0;
      buf1     <= '0;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) begin
        if (addr == LAST_ADDR) begin
          addr <= '0;
          pass <= (pass == LAST_PASS) ? '0 : pass + 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) buf0 <= bus.weight_V_q0;
          else               buf1 <= bus.weight_V_q0;
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0  <= buf1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf0 <= bus.weight_V_q0;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.weight_V_q0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_done               = (state == S_DONE);
  assign ap_idle               = (state == S_IDLE);
  assign state_dbg             = state;
  assign bus.weight_V_ce0      = issue;
  assign bus.weight_V_address0 = addr;
  assign bus.output_V_din      = buf0;
  assign bus.output_V_write    = pop;

endmodule

// File: tb/tb_weight_stream_gen.sv
// Randomised bench for weight_stream_gen: three configurations, a queue-based
// reference stream per instance and independent negedge monitors.
module tb_weight_stream_gen;

  logic clk = 1'b0;
  logic ap_rst;
  logic start_a, start_c, start_d;
  logic done_a, done_c, done_d;
  logic idle_a, idle_c, idle_d;
  logic [1:0] st_a, st_c, st_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // A: LANES=4 x 8b, KERN_SIZE=4, REPEAT=2
  weight_stream_gen_if #(.ADDR_W(2), .DATA_W(32)) bus_a ();
  // C: continuous, KERN_SIZE=3, REPEAT=1
  weight_stream_gen_if #(.ADDR_W(2), .DATA_W(16)) bus_c ();
  // D: KERN_SIZE=1, REPEAT=3
  weight_stream_gen_if #(.ADDR_W(1), .DATA_W(16)) bus_d ();

  weight_stream_gen #(.COEFF_WIDTH(8), .LANES(4), .KERN_SIZE(4), .REPEAT(2), .CONTINUOUS(0)) dut_a (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(start_a), .ap_done(done_a),
    .ap_idle(idle_a), .state_dbg(st_a), .bus(bus_a));
  weight_stream_gen #(.COEFF_WIDTH(16), .LANES(1), .KERN_SIZE(3), .REPEAT(1), .CONTINUOUS(1)) dut_c (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(start_c), .ap_done(done_c),
    .ap_idle(idle_c), .state_dbg(st_c), .bus(bus_c));
  weight_stream_gen #(.COEFF_WIDTH(16), .LANES(1), .KERN_SIZE(1), .REPEAT(3), .CONTINUOUS(0)) dut_d (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(start_d), .ap_done(done_d),
    .ap_idle(idle_d), .state_dbg(st_d), .bus(bus_d));

  // ROM models, 1-cycle read latency
  logic [31:0] rom_a [4];
  logic [15:0] rom_c [3];
  logic [15:0] rom_d;

  always @(posedge clk) begin
    if (bus_a.weight_V_ce0) bus_a.weight_V_q0 <= rom_a[bus_a.weight_V_address0];
    if (bus_c.weight_V_ce0)
      bus_c.weight_V_q0 <= (bus_c.weight_V_address0 < 2'd3) ? rom_c[bus_c.weight_V_address0] : 16'hdead;
    if (bus_d.weight_V_ce0) bus_d.weight_V_q0 <= rom_d;
  end

  // Scoreboard queues
  logic [31:0] exp_a[$];
  logic [15:0] exp_c[$];
  logic [15:0] exp_d[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor A ----------------
  int   wr_a = 0, since_a = 100;
  logic prev_wr_a = 1'b0, prev_done_a = 1'b0;
  logic quiet_a = 1'b0;

  always @(negedge clk) begin
    if (!ap_rst) begin
      if (idle_a || done_a) check("a_ce0_outside_run", 32'(bus_a.weight_V_ce0), 32'd0);
      if (quiet_a) begin
        check("a_write_after_reset", 32'(bus_a.output_V_write), 32'd0);
        check("a_idle_after_reset", 32'(idle_a), 32'd1);
      end else begin
        if (idle_a && start_a) begin since_a = 0; wr_a = 0; end
        else since_a++;
        if (since_a == 3 && bus_a.output_V_full_n)
          check("a_first_write_latency", 32'(bus_a.output_V_write), 32'd1);
        if (!bus_a.output_V_full_n && wr_a > 0 && wr_a < 8 && exp_a.size() > 0)
          check("a_din_held", bus_a.output_V_din, exp_a[0]);
        if (bus_a.output_V_write) begin
          if (exp_a.size() == 0) flag("a_extra_write", $sformatf("din %0h with empty queue", bus_a.output_V_din));
          else check("a_din", bus_a.output_V_din, exp_a.pop_front());
          wr_a++;
        end
        if (done_a) begin
          check("a_words_per_run", 32'(wr_a), 32'd8);
          check("a_done_after_last_write", 32'(prev_wr_a), 32'd1);
        end
        if (prev_done_a) check("a_idle_after_done", 32'(idle_a), 32'd1);
        prev_wr_a   = bus_a.output_V_write;
        prev_done_a = done_a;
      end
    end
  end

  // ---------------- monitor C ----------------
  int   wr_c = 0;
  logic prev_wr_c = 1'b0;
  logic en_c = 1'b0;

  always @(negedge clk) begin
    if (!ap_rst && en_c) begin
      if (idle_c || done_c) check("c_ce0_outside_run", 32'(bus_c.weight_V_ce0), 32'd0);
      if (bus_c.output_V_write) begin
        if (exp_c.size() == 0) flag("c_extra_write", $sformatf("din %0h with empty queue", bus_c.output_V_din));
        else check("c_din", 32'(bus_c.output_V_din), 32'(exp_c.pop_front()));
        wr_c++;
      end
      if (done_c) begin
        check("c_words_per_pass", 32'(wr_c), 32'd3);
        check("c_done_after_last_write", 32'(prev_wr_c), 32'd1);
        wr_c = 0;
      end
      prev_wr_c = bus_c.output_V_write;
    end
  end

  // ---------------- monitor D ----------------
  int   wr_d = 0, since_d = 100, idle_run_d = 0;
  logic prev_wr_d = 1'b0, chain_d = 1'b0;

  always @(negedge clk) begin
    if (!ap_rst) begin
      if (idle_d || done_d) check("d_ce0_outside_run", 32'(bus_d.weight_V_ce0), 32'd0);
      if (bus_d.weight_V_ce0) check("d_address_zero", 32'(bus_d.weight_V_address0), 32'd0);
      if (idle_d && start_d) begin since_d = 0; wr_d = 0; end
      else since_d++;
      if (idle_d) idle_run_d++;
      if (since_d == 3 && bus_d.output_V_full_n)
        check("d_first_write_latency", 32'(bus_d.output_V_write), 32'd1);
      if (bus_d.output_V_write) begin
        if (exp_d.size() == 0) flag("d_extra_write", $sformatf("din %0h with empty queue", bus_d.output_V_din));
        else check("d_din", 32'(bus_d.output_V_din), 32'(exp_d.pop_front()));
        wr_d++;
      end
      if (done_d) begin
        check("d_words_per_run", 32'(wr_d), 32'd3);
        check("d_done_after_last_write", 32'(prev_wr_d), 32'd1);
        if (chain_d) check("d_idle_cycles_between_runs", 32'(idle_run_d), 32'd1);
        chain_d    = start_d;
        idle_run_d = 0;
      end
      prev_wr_d = bus_d.output_V_write;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_a();
    check("a_rst_idle", 32'(idle_a), 32'd1);
    check("a_rst_done", 32'(done_a), 32'd0);
    check("a_rst_write", 32'(bus_a.output_V_write), 32'd0);
    check("a_rst_ce0", 32'(bus_a.weight_V_ce0), 32'd0);
    check("a_rst_addr", 32'(bus_a.weight_V_address0), 32'd0);
    check("a_rst_din", bus_a.output_V_din, 32'd0);
  endtask

  task automatic apply_reset_a();
    ap_rst = 1'b1;
    bus_a.output_V_full_n = 1'b1;
    cyc();
    check_reset_a();
    ap_rst = 1'b0;
    exp_a.delete();
    quiet_a = 1'b1;
    repeat (10) cyc();
    quiet_a = 1'b0;
  endtask

  // mode 0: full_n high; 1: random 50%; 2: low for run cycles 3..5
  task automatic run_a(input int mode, input int rst_after);
    logic ok = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) exp_a.push_back(rom_a[i]);
    start_a = 1'b1;
    bus_a.output_V_full_n = 1'b1;
    cyc();
    start_a = 1'b0;
    for (int c = 1; c < 400; c++) begin
      case (mode)
        1:       bus_a.output_V_full_n = 1'($urandom_range(0, 1));
        2:       bus_a.output_V_full_n = !(c >= 4 && c <= 6);
        default: bus_a.output_V_full_n = 1'b1;
      endcase
      cyc();
      if (rst_after > 0 && wr_a >= rst_after) begin
        apply_reset_a();
        return;
      end
      if (done_a) begin ok = 1'b1; break; end
    end
    if (!ok) flag("a_done_timeout", "no ap_done within 400 cycles");
    bus_a.output_V_full_n = 1'b1;
    cyc();
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    exp_a.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dones;
    ap_rst = 1'b1;
    start_a = 1'b0; start_c = 1'b0; start_d = 1'b0;
    bus_a.output_V_full_n = 1'b1;
    bus_c.output_V_full_n = 1'b1;
    bus_d.output_V_full_n = 1'b1;
    for (int i = 0; i < 4; i++) rom_a[i] = 32'(i + 1);
    for (int i = 0; i < 3; i++) rom_c[i] = 16'(i + 1);
    rom_d = 16'h1234;
    cyc();
    cyc();
    check_reset_a();
    check("c_rst_idle", 32'(idle_c), 32'd1);
    check("c_rst_ce0", 32'(bus_c.weight_V_ce0), 32'd0);
    check("c_rst_din", 32'(bus_c.output_V_din), 32'd0);
    check("d_rst_idle", 32'(idle_d), 32'd1);
    check("d_rst_write", 32'(bus_d.output_V_write), 32'd0);
    ap_rst = 1'b0;
    cyc();

    // T1 / T2: ascending kernel, free-running then a stall window
    run_a(0, 0);
    run_a(2, 0);

    // T3: random lanes and random backpressure, 125 runs x 8 words
    for (int r = 0; r < 125; r++) begin
      for (int i = 0; i < 4; i++) rom_a[i] = $urandom();
      run_a(1, 0);
    end

    // T4: reset after the third word, then a clean restart
    for (int i = 0; i < 4; i++) rom_a[i] = 32'(i + 1);
    run_a(0, 3);
    run_a(0, 0);

    // T6: KERN_SIZE=1, start held high, random backpressure, 5 runs
    rom_d = 16'($urandom());
    for (int i = 0; i < 15; i++) exp_d.push_back(rom_d);
    start_d = 1'b1;
    dones = 0;
    for (int c = 0; c < 600 && dones < 5; c++) begin
      bus_d.output_V_full_n = 1'($urandom_range(0, 1));
      cyc();
      if (done_d) dones++;
    end
    start_d = 1'b0;
    if (dones < 5) flag("d_done_timeout", $sformatf("%0d of 5 runs finished", dones));
    bus_d.output_V_full_n = 1'b1;
    repeat (5) cyc();
    check("d_stays_idle", 32'(idle_d), 32'd1);
    check("d_queue_drained", 32'(exp_d.size()), 32'd0);

    // T5: continuous mode, 6 passes of 1,2,3
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 3; i++) exp_c.push_back(16'(i + 1));
    en_c = 1'b1;
    start_c = 1'b1;
    cyc();
    start_c = 1'b0;
    dones = 0;
    for (int c = 0; c < 300 && dones < 6; c++) begin
      cyc();
      if (done_c) dones++;
    end
    if (dones < 6) flag("c_done_timeout", $sformatf("%0d of 6 passes finished", dones));
    cyc();
    en_c = 1'b0;
    check("c_queue_drained", 32'(exp_c.size()), 32'd0);
    ap_rst = 1'b1;
    cyc();
    ap_rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
